// File: rtl/uart_rx_frontend_if.sv
// Write port of the downstream 8-bit receive FIFO.
// The master side strobes bytes in and the slave side reports full.
interface uart_rx_frontend_if;
  logic       w_enable;
  logic [7:0] w_data;
  logic       fifo_full;

  modport master (output w_enable, output w_data, input fifo_full);
  modport slave  (input w_enable, input w_data, output fifo_full);
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: it oversamples serial_in, frames characters
// and writes each good byte into the receive FIFO.
module uart_rx_frontend #(
  parameter int unsigned BIT_PERIOD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  uart_rx_frontend_if.master  fifo,
  output logic                framing_error,
  output logic                overrun_error,
  output logic                busy
);

  localparam int unsigned Half = BIT_PERIOD / 2;
  localparam int unsigned Cw   = $clog2(BIT_PERIOD);

  localparam logic [Cw-1:0] HalfM1   = Cw'(Half - 1);
  localparam logic [Cw-1:0] BitM1    = Cw'(BIT_PERIOD - 1);
  localparam logic [Cw-1:0] TimerOne = Cw'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWrite,
    StWaitHigh
  } state_e;

  state_e        state;
  logic          sync_meta;
  logic          synced;
  logic          delayed;
  logic [Cw-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    data_hold;
  logic          in_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta     <= 1'b1;
      synced        <= 1'b1;
      delayed       <= 1'b1;
      state         <= StIdle;
      timer         <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      data_hold     <= '0;
      framing_error <= 1'b0;
    end else begin
      sync_meta     <= serial_in;
      synced        <= sync_meta;
      delayed       <= synced;
      framing_error <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!synced && delayed) begin
            timer   <= HalfM1;
            bit_cnt <= 3'd7;
            shift   <= '0;
            state   <= StStart;
          end
        end
        StStart: begin
          if (timer != '0) begin
            timer <= timer - TimerOne;
          end else begin
            timer <= BitM1;
            // A line already high again at mid-bit was only a glitch.
            state <= synced ? StIdle : StData;
          end
        end
        StData: begin
          if (timer != '0) begin
            timer <= timer - TimerOne;
          end else begin
            timer <= BitM1;
            shift <= {synced, shift[7:1]};
            if (bit_cnt == 3'd0) begin
              state <= StStop;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
        end
        StStop: begin
          if (timer != '0) begin
            timer <= timer - TimerOne;
          end else begin
            timer <= '0;
            if (synced) begin
              state <= StWrite;
            end else begin
              framing_error <= 1'b1;
              state         <= StWaitHigh;
            end
          end
        end
        StWrite: begin
          if (!fifo.fifo_full) begin
            data_hold <= shift;
          end
          state <= StIdle;
        end
        StWaitHigh: begin
          // Hold off until the line idles so a stuck-low line cannot retrigger.
          if (synced) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // FIFO full is looked at only in the write cycle, so the strobe is decoded there.
  assign in_write      = (state == StWrite) && !rst;
  assign fifo.w_enable = in_write && !fifo.fifo_full;
  assign overrun_error = in_write && fifo.fifo_full;
  assign fifo.w_data   = fifo.w_enable ? shift : data_hold;
  assign busy          = (state != StIdle);

endmodule
